alu_instr_encoder: RTL

- Streaming instruction encoder: takes an ALU operation (`ALUop.vh` encoding), an operand form and register/immediate fields, and emits 32-bit MIPS instruction words.
- Source of instruction streams for the BIOS loader and the datapath test harness, which write them into instruction memory.
- Registered encode stage, two-word constant-load expansion FSM and output FIFO, with valid/ready on both sides.

---
 rtl/alu_instr_encoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_instr_encoder.sv
// Streaming MIPS instruction encoder with a two-word constant-load FSM and an output FIFO.
// Optional build macro LI_SHORT_EN: constant loads collapse to one word when the value allows it.
module alu_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alu_op,
    input  logic [1:0]  in_form,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err_illegal,
    output logic [7:0]  illegal_cnt
);
    // ALUop.vh operation codes; 12..15 are undefined.
    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT2
    } state_t;

    state_t        state_q;
    logic [31:0]   pend_q;
    logic          err_q;
    logic [7:0]    cnt_q;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    logic [5:0]    funct;
    logic [5:0]    opcode;
    logic [31:0]   enc_word;
    logic [31:0]   enc_second;
    logic          enc_legal;
    logic          enc_two;
    logic          fifo_full;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   push_data;

    always_comb begin
        funct      = 6'h00;
        opcode     = 6'h00;
        enc_legal  = 1'b1;
        enc_two    = 1'b0;
        enc_word   = '0;
        enc_second = '0;
        case (in_form)
            2'd0: begin
                case (in_alu_op)
                    OP_ADDU: funct = 6'h21;
                    OP_SUBU: funct = 6'h23;
                    OP_AND:  funct = 6'h24;
                    OP_OR:   funct = 6'h25;
                    OP_XOR:  funct = 6'h26;
                    OP_NOR:  funct = 6'h27;
                    OP_SLT:  funct = 6'h2A;
                    OP_SLTU: funct = 6'h2B;
                    OP_SLL:  funct = 6'h04;
                    OP_SRL:  funct = 6'h06;
                    OP_SRA:  funct = 6'h07;
                    default: enc_legal = 1'b0;
                endcase
                enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, funct};
            end
            2'd1: begin
                case (in_alu_op)
                    OP_SLL:  funct = 6'h00;
                    OP_SRL:  funct = 6'h02;
                    OP_SRA:  funct = 6'h03;
                    default: enc_legal = 1'b0;
                endcase
                enc_word = {6'h00, 5'd0, in_rt, in_rd, in_imm[4:0], funct};
            end
            2'd2: begin
                case (in_alu_op)
                    OP_ADDU: opcode = 6'h09;
                    OP_SLT:  opcode = 6'h0A;
                    OP_SLTU: opcode = 6'h0B;
                    OP_AND:  opcode = 6'h0C;
                    OP_OR:   opcode = 6'h0D;
                    OP_XOR:  opcode = 6'h0E;
                    OP_LUI:  opcode = 6'h0F;
                    default: enc_legal = 1'b0;
                endcase
                enc_word = {opcode, (in_alu_op == OP_LUI) ? 5'd0 : in_rs, in_rt, in_imm[15:0]};
            end
            default: begin
                enc_word   = {6'h0F, 5'd0, in_rt, in_imm[31:16]};
                enc_second = {6'h0D, in_rt, in_rt, in_imm[15:0]};
                enc_two    = 1'b1;
`ifdef LI_SHORT_EN
                if (in_imm[31:16] == 16'h0000) begin
                    enc_word = {6'h0D, 5'd0, in_rt, in_imm[15:0]};
                    enc_two  = 1'b0;
                end else if (&in_imm[31:15]) begin
                    enc_word = {6'h09, 5'd0, in_rt, in_imm[15:0]};
                    enc_two  = 1'b0;
                end else if (in_imm[15:0] == 16'h0000) begin
                    enc_two  = 1'b0;
                end
`endif
            end
        endcase
    end

    // in_ready deliberately ignores a same-cycle pop to keep it off the out_ready path.
    assign fifo_full   = (count_q == (AW+1)'(DEPTH));
    assign in_ready    = (state_q == ST_IDLE) && !fifo_full;
    assign accept      = in_valid && in_ready;
    assign push        = (state_q == ST_EMIT2) ? !fifo_full : (accept && enc_legal);
    assign push_data   = (state_q == ST_EMIT2) ? pend_q : enc_word;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign out_instr   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign err_illegal = err_q;
    assign illegal_cnt = cnt_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            err_q <= accept && !enc_legal;
            if (accept && !enc_legal && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept && enc_legal && enc_two) begin
                        state_q <= ST_EMIT2;
                        pend_q  <= enc_second;
                    end
                end
                default: begin
                    if (!fifo_full) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: out_instr is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
